cam_capture: RTL

//  Camera capture front end. Samples OV7670-style vsync/href/8-bit byte stream
//  (RGB565, two bytes per pixel) and packs each pixel to RGB332. Emits one

---
 rtl/cam_capture.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cam_capture.sv
`timescale 1ns/1ps
// cam_capture: samples an OV7670-style RGB565 byte stream, packs each pixel to RGB332 and
// emits linear framebuffer writes, flagging malformed lines and overflowing frames.
module cam_capture #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic          px_wr,
  output logic [AW-1:0] px_addr,
  output logic [7:0]    px_data,
  output logic          frame_done,
  output logic          line_err,
  output logic          ovf
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int LW   = $clog2(IMG_H + 2);
  localparam int PW   = $clog2(IMG_W + 2);

  typedef enum logic [1:0] {WAIT_SOF, IDLE_LINE, BYTE_B, BYTE_A} state_t;

  state_t        state_q, state_d;
  logic          vsync_q, vs_ok_q;
  logic [5:0]    a_q, a_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] line_q, line_d;
  logic [PW-1:0] pix_q, pix_d;
  logic          px_wr_q, px_wr_d;
  logic [AW-1:0] px_addr_q, px_addr_d;
  logic [7:0]    px_data_q, px_data_d;
  logic          done_q, done_d;
  logic          lerr_q, lerr_d;
  logic          ovf_q, ovf_d;
  logic          sof, eof, open_line;

  // vs_ok_q keeps the reset value of vsync_q from faking a vsync fall on the first edge
  assign sof       = vs_ok_q & vsync_q & ~CAM_vsync;
  assign eof       = ~vsync_q & CAM_vsync;
  assign open_line = (state_q == BYTE_B) || (state_q == BYTE_A);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    addr_d    = addr_q;
    line_d    = line_q;
    pix_d     = pix_q;
    px_wr_d   = 1'b0;
    px_addr_d = px_addr_q;
    px_data_d = px_data_q;
    done_d    = 1'b0;
    lerr_d    = lerr_q;
    ovf_d     = ovf_q;
    if (open_line && (eof || !CAM_href)) begin
      line_d = (line_q == LW'(IMG_H + 1)) ? line_q : line_q + 1'b1;
      if (state_q == BYTE_B || pix_q != PW'(IMG_W)) lerr_d = 1'b1;
    end
    if (state_q == WAIT_SOF) begin
      if (sof) begin
        addr_d  = '0;
        line_d  = '0;
        lerr_d  = 1'b0;
        ovf_d   = 1'b0;
        state_d = IDLE_LINE;
      end
    end else if (eof) begin
      done_d  = (addr_q == AW'(NPIX)) && (line_d == LW'(IMG_H)) && !ovf_q;
      state_d = WAIT_SOF;
    end else if (CAM_href) begin
      if (state_q == BYTE_B) begin
        pix_d   = (pix_q == PW'(IMG_W + 1)) ? pix_q : pix_q + 1'b1;
        state_d = BYTE_A;
        if (addr_q == AW'(NPIX)) ovf_d = 1'b1;
        else begin
          px_wr_d   = 1'b1;
          px_addr_d = addr_q;
          px_data_d = {a_q, CAM_px_data[4:3]};
          addr_d    = addr_q + 1'b1;
        end
      end else begin
        a_d     = {CAM_px_data[7:5], CAM_px_data[2:0]};
        pix_d   = (state_q == IDLE_LINE) ? '0 : pix_q;
        state_d = BYTE_B;
      end
    end else begin
      state_d = IDLE_LINE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WAIT_SOF;
      vsync_q   <= 1'b1;
      vs_ok_q   <= 1'b0;
      a_q       <= '0;
      addr_q    <= '0;
      line_q    <= '0;
      pix_q     <= '0;
      px_wr_q   <= 1'b0;
      px_addr_q <= '0;
      px_data_q <= '0;
      done_q    <= 1'b0;
      lerr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vsync_q   <= CAM_vsync;
      vs_ok_q   <= 1'b1;
      a_q       <= a_d;
      addr_q    <= addr_d;
      line_q    <= line_d;
      pix_q     <= pix_d;
      px_wr_q   <= px_wr_d;
      px_addr_q <= px_addr_d;
      px_data_q <= px_data_d;
      done_q    <= done_d;
      lerr_q    <= lerr_d;
      ovf_q     <= ovf_d;
    end
  end

  assign px_wr      = px_wr_q;
  assign px_addr    = px_addr_q;
  assign px_data    = px_data_q;
  assign frame_done = done_q;
  assign line_err   = lerr_q;
  assign ovf        = ovf_q;
endmodule
